// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, operation type and shifter modes.
// Also imported by the ALU control block, so encodings here are the contract.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int SHAMT_W   = 5;

  // Raw 4-bit code. The bus can carry encodings with no assigned meaning,
  // so this is a plain vector rather than a closed enum.
  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_XOR  = 4'b0011;
  localparam alu_op_t ALU_SLL  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SLT  = 4'b0111;
  localparam alu_op_t ALU_SLTU = 4'b1000;
  localparam alu_op_t ALU_SRA  = 4'b1001;
  localparam alu_op_t ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    SHIFT_LL = 2'd0,  // logical left
    SHIFT_RL = 2'd1,  // logical right
    SHIFT_RA = 2'd2   // arithmetic right
  } shift_mode_t;

  // Map an opcode onto the shifter's mode; non-shift codes fold onto a
  // harmless right-logical setting because the result mux ignores them.
  function automatic shift_mode_t shift_mode_of(input alu_op_t op);
    shift_mode_t mode;
    case (op)
      ALU_SLL: mode = SHIFT_LL;
      ALU_SRA: mode = SHIFT_RA;
      default: mode = SHIFT_RL;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: log2(WIDTH) stages of conditional shifts.
// Left shifts reuse the right-shift network by bit-reversing in and out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_B = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_B-1:0] shamt,
  input  shift_mode_t        mode,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] shifted;
  logic             fill;

  // Present the operand to the right-shift network, reversed for left shifts.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    data_in = data;
    if (mode == SHIFT_LL) begin
      for (int i = 0; i < WIDTH; i++) begin
        data_in[i] = data[WIDTH-1-i];
      end
    end
  end

  // Only arithmetic right shifts replicate the sign bit into vacated bits.
  assign fill = (mode == SHIFT_RA) ? data[WIDTH-1] : 1'b0;

  // Right-shift network: stage s moves by 2**s when shamt[s] is set.
  always_comb begin
    shifted = data_in;
    for (int s = 0; s < SHAMT_B; s++) begin
      if (shamt[s]) begin
        shifted = (shifted >> (1 << s))
                | (fill ? ~({WIDTH{1'b1}} >> (1 << s)) : {WIDTH{1'b0}});
      end
    end
  end

  // Undo the input reversal for left shifts.
  always_comb begin
    result = shifted;
    if (mode == SHIFT_LL) begin
      for (int i = 0; i < WIDTH; i++) begin
        result[i] = shifted[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/alu.sv
// EX-stage integer ALU: logic ops, add/sub with signed-overflow detect,
// signed/unsigned set-less-than and shifts, with registered result, zero
// and overflow flags (one cycle latency, new operation every cycle).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  alu_op_t          operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow
);

  localparam int SHAMT_B = $clog2(WIDTH);

  logic             is_sub;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] shift_result;
  logic [WIDTH-1:0] next_result;
  logic             next_ovf;

  // Shared adder: subtraction is data1 + ~data2 + 1.
  assign is_sub    = (operation == ALU_SUB);
  assign operand_b = is_sub ? ~data2 : data2;
  assign sum       = data1 + operand_b + {{(WIDTH-1){1'b0}}, is_sub};

  // Signed overflow: both adder inputs share a sign the sum does not have.
  // Using the (possibly inverted) second operand covers ADD and SUB alike.
  assign sum_ovf = (data1[WIDTH-1] == operand_b[WIDTH-1]) &&
                   (sum[WIDTH-1]   != data1[WIDTH-1]);

  // True magnitude compares, so SLT stays correct when data1 - data2 wraps.
  assign lt_signed   = $signed(data1) < $signed(data2);
  assign lt_unsigned = data1 < data2;

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_B (SHAMT_B)
  ) u_shifter (
    .data   (data2),
    .shamt  (data1[SHAMT_B-1:0]),
    .mode   (shift_mode_of(operation)),
    .result (shift_result)
  );

  // Result and overflow select; unassigned opcodes produce zero.
  always_comb begin
    next_result = '0;
    next_ovf    = 1'b0;
    case (operation)
      ALU_AND:  next_result = data1 & data2;
      ALU_OR:   next_result = data1 | data2;
      ALU_XOR:  next_result = data1 ^ data2;
      ALU_NOR:  next_result = ~(data1 | data2);
      ALU_ADD,
      ALU_SUB: begin
        next_result = sum;
        next_ovf    = sum_ovf;
      end
      ALU_SLT:  next_result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU: next_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  next_result = shift_result;
      default: begin
        next_result = '0;
        next_ovf    = 1'b0;
      end
    endcase
  end

  // Output registers; zero is computed from the same next value so it can
  // never disagree with alu_result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      alu_result <= '0;
      zero       <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      alu_result <= next_result;
      zero       <= (next_result == '0);
      overflow   <= next_ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases followed by a random
// run compared against a plain-arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  alu_op_t     operation = '0;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .data1      (data1),
    .data2      (data2),
    .operation  (operation),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model straight from the opcode table, using wide signed math
  // for overflow instead of sign-bit rules.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = sa + sb; r = s[31:0]; v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      4'b0011: r = a ^ b;
      4'b0100: r = b << a[4:0];
      4'b0101: r = b >> a[4:0];
      4'b0110: begin s = sa - sb; r = s[31:0]; v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: r = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
      4'b1001: r = 32'($signed(b) >>> a[4:0]);
      4'b1100: r = ~(a | b);
      default: begin r = 32'h0; v = 1'b0; end
    endcase
  endfunction

  // Apply one operation, clock it, and sample just after the edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op;
    data1     = a;
    data2     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic ovf);
    check({tag, "_result"},   alu_result, res);
    check({tag, "_zero"},     {31'h0, zero}, {31'h0, (res == 32'h0)});
    check({tag, "_overflow"}, {31'h0, overflow}, {31'h0, ovf});
  endtask

  logic [31:0] specials [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                32'h8000_0000, 32'h1F, 32'h20, 32'hFFFF_FFF6};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  initial begin
    logic [31:0] exp_r, prev_r, a, b;
    logic        exp_v, prev_v;
    logic [3:0]  op;

    // Reset held with random operands.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'($urandom_range(0, 15)), $urandom(), $urandom());
      expect_out($sformatf("reset%0d", i), 32'h0, 1'b0);
    end
    rst = 1'b0;

    drive(ALU_ADD, 32'd2, 32'd1);                   expect_out("add_basic", 32'd3, 1'b0);
    drive(ALU_SUB, 32'd2, 32'd2);                   expect_out("sub_zero", 32'h0, 1'b0);
    drive(ALU_SUB, 32'h8000_0000, 32'd1);           expect_out("sub_ovf", 32'h7FFF_FFFF, 1'b1);
    drive(ALU_AND, 32'd10, 32'd6);                  expect_out("and", 32'd2, 1'b0);
    drive(ALU_OR, 32'd10, 32'd5);                   expect_out("or", 32'd15, 1'b0);
    drive(ALU_NOR, 32'd0, 32'd0);                   expect_out("nor", 32'hFFFF_FFFF, 1'b0);
    drive(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);   expect_out("xor", 32'h0F0F_F0F0, 1'b0);
    drive(ALU_SLT, 32'hFFFF_FFF6, 32'd5);           expect_out("slt_neg", 32'd1, 1'b0);
    drive(ALU_SLTU, 32'hFFFF_FFF6, 32'd5);          expect_out("sltu_big", 32'd0, 1'b0);
    drive(ALU_SLT, 32'h8000_0000, 32'd1);           expect_out("slt_wrap", 32'd1, 1'b0);
    drive(ALU_SLT, 32'd5, 32'd5);                   expect_out("slt_eq", 32'd0, 1'b0);
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1);           expect_out("add_ovf", 32'h8000_0000, 1'b1);
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd1);           expect_out("add_wrap0", 32'h0, 1'b0);
    drive(ALU_SLL, 32'd31, 32'd1);                  expect_out("sll31", 32'h8000_0000, 1'b0);
    drive(ALU_SRL, 32'd4, 32'h8000_0000);           expect_out("srl4", 32'h0800_0000, 1'b0);
    drive(ALU_SRA, 32'd4, 32'h8000_0000);           expect_out("sra4", 32'hF800_0000, 1'b0);
    drive(ALU_SRA, 32'h20, 32'h8123_4567);          expect_out("sra_sh0", 32'h8123_4567, 1'b0);
    drive(ALU_SLL, 32'hFFFF_FFE0, 32'h1234_5678);   expect_out("sll_sh0", 32'h1234_5678, 1'b0);
    drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   expect_out("undef_op", 32'h0, 1'b0);

    // Back-to-back random operations, each checked one edge later, plus a
    // check that nothing reaches the outputs before the edge.
    prev_r = 32'h0;
    prev_v = 1'b0;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      if (i == 150) begin
        rst = 1'b1;
        drive(op, a, b);
        expect_out("mid_reset", 32'h0, 1'b0);
        rst = 1'b0;
        prev_r = 32'h0;
        prev_v = 1'b0;
      end else begin
        operation = op;
        data1     = a;
        data2     = b;
        #1;
        check($sformatf("hold%0d", i), alu_result, prev_r);
        @(posedge clk);
        #1;
        model(op, a, b, exp_r, exp_v);
        expect_out($sformatf("rand%0d_op%0h", i, op), exp_r, exp_v);
        prev_r = exp_r;
        prev_v = exp_v;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit MIPS-style integer ALU for the EX stage of the pipeline.
- Combinationally evaluates `data1 op data2` from a 4-bit `operation` code supplied by ALU control.
- Registers the result and status flags on the rising clock edge.
- Feeds the EX/MEM pipeline register and the branch-compare logic (via `zero`).

Parameters:
- WIDTH, 32, datapath width in bits. Only 32 is required to work.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data1  input  32  operand A (rs); also supplies the shift amount for shift ops.
- data2  input  32  operand B (rt or sign-extended immediate); the value shifted by shift ops.
- operation  input  4  ALU operation code.
- alu_result  output  32  registered result.
- zero  output  1  registered flag, 1 when the registered result equals 0.
- overflow  output  1  registered signed-overflow flag; meaningful for ADD/SUB only.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: on a clock edge with rst=1, alu_result=0, zero=1, overflow=0. Reset has priority over any operation.
- Latency: exactly 1 cycle. Operands and opcode sampled at edge N appear on the outputs after edge N.
- No handshake; a new operation is accepted every cycle.
- Outputs hold their value only while inputs are unchanged; there is no enable.
- Opcodes (result = f(data1, data2)):
  - 0000 AND: data1 & data2
  - 0001 OR: data1 | data2
  - 0010 ADD: data1 + data2, modulo 2^32
  - 0011 XOR: data1 ^ data2
  - 0100 SLL: data2 << data1[4:0]
  - 0101 SRL: data2 >> data1[4:0], logical
  - 0110 SUB: data1 - data2, modulo 2^32
  - 0111 SLT: 1 if $signed(data1) < $signed(data2), else 0
  - 1000 SLTU: 1 if data1 < data2 unsigned, else 0
  - 1001 SRA: data2 >>> data1[4:0], arithmetic
  - 1100 NOR: ~(data1 | data2)
  - Any other code: result 0, overflow 0.
- Overflow:
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from data1.
  - All other ops: 0.
  - The result is still the wrapped value when overflow is set; no trapping.
- SLT must be correct even when data1 - data2 overflows (e.g. 0x80000000 vs 1 gives 1). Implement it as a true signed compare, not as the sign bit of the difference.
- Shift amounts use only data1[4:0]; data1[31:5] is ignored. A shift by 0 returns data2 unchanged.
- zero is derived from the next-result value and registered alongside it, so it always matches alu_result.
- X on operation outside reset: no requirement. A bench must not drive X after reset deasserts.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_NOR.
  - A typedef alu_op_t.
  - The package is also used by ALU control.
- One natural sub-module, alu_shifter: combinational barrel shifter taking data, shamt[4:0] and mode (SLL/SRL/SRA).
- The top level holds the adder/subtractor, compare, logic ops, result mux and output registers.

Test Plan:
- Reset: rst=1 for several cycles with random operands -> alu_result=0, zero=1, overflow=0. Release rst, then data1=2, data2=1, op=0010 -> next cycle alu_result=3, zero=0, overflow=0.
- SUB/zero: data1=2, data2=2, op=0110 -> alu_result=0, zero=1. Overflow case: 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1.
- Logic ops:
  - AND 10 & 6 -> 2.
  - OR 10 | 5 -> 15.
  - NOR 0 and 0 -> 0xFFFFFFFF.
  - XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> 0x0F0FF0F0.
- SLT/SLTU:
  - SLT data1=-10 (0xFFFFFFF6), data2=5 -> 1.
  - SLTU on same operands -> 0.
  - SLT 0x80000000 vs 1 -> 1.
  - SLT 5 vs 5 -> 0.
- ADD overflow: 0x7FFFFFFF + 1 -> alu_result=0x80000000, overflow=1. Also 0xFFFFFFFF + 1 -> 0, zero=1, overflow=0.
- Shifts:
  - SLL data2=1, data1=31 -> 0x80000000.
  - SRL data2=0x80000000, data1=4 -> 0x08000000.
  - SRA same operands -> 0xF8000000.
  - data1=0x20 (low 5 bits 0) -> data2 unchanged.
- Back-to-back and reset mid-stream: change op every cycle -> each result appears exactly 1 cycle later. Asserting rst in the middle clears outputs on that edge.
